regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_clr_fsm.sv | 61 ++++++
 rtl/regfile_param.sv | 82 ++++++++
 tb/tb_regfile_param.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the parameterised register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    // Clear sequencer states
    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_DEPTH = 8;

endpackage : regfile_pkg

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks a pointer across every entry, one entry per cycle.
// Latency: a full clear takes exactly DEPTH cycles after the clr_req edge.
// Backpressure: busy stays high for the whole sequence; clr_req while busy is ignored.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = REGFILE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          CLRn,
    input  logic          clr_req,
    output logic          busy,
    output logic [AW-1:0] clr_ptr,
    output logic          clr_we
);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] ptr_nxt;

    // State and pointer registers; reset aborts any clear in progress
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
        end
    end

    // Next state: start on request, step the pointer, leave after the last entry
    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEARING;
                    ptr_nxt   = '0;
                end
            end
            CLEARING: begin
                // DEPTH is a power of two, so the increment wraps to 0 after the last entry
                ptr_nxt = clr_ptr + AW'(1);
                if (clr_ptr == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign busy   = (state == CLEARING);
    assign clr_we = (state == CLEARING);

endmodule : regfile_clr_fsm

// File: rtl/regfile_param.sv
// Two-read/one-write register file with a sequenced clear; REGFILE_BYPASS_EN adds write-through forwarding.
// Latency: reads are combinational; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: wr_ready = !busy; a write presented while a clear runs is dropped and must be held.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH = REGFILE_WIDTH,
    parameter  int DEPTH = REGFILE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             CLRn,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [AW-1:0]    WrAddr,
    input  logic             regWE,
    output logic             wr_ready,
    input  logic [AW-1:0]    RdAddrA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] DataOutA,
    output logic [WIDTH-1:0] DataOutB,
    input  logic             clr_req,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    clr_ptr;
    logic             clr_we;
    logic             wr_acc;

    regfile_clr_fsm #(
        .DEPTH (DEPTH)
    ) u_clr_fsm (
        .clk     (clk),
        .CLRn    (CLRn),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_ptr (clr_ptr),
        .clr_we  (clr_we)
    );

    assign wr_ready = ~busy;
    assign wr_acc   = regWE & wr_ready;

    // Storage: reset zeroes everything; clear and user writes never coincide since wr_ready = !busy
    always_ff @(posedge clk or negedge CLRn) begin
        if (!CLRn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            mem[WrAddr] <= DataIn;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd;

    // Forward only a write that will really commit; gating with CLRn keeps outputs at zero in reset
    assign fwd = wr_acc & CLRn;

    // Read ports with write-through forwarding
    always_comb begin
        DataOutA = mem[RdAddrA];
        DataOutB = mem[RdAddrB];
        if (fwd && (RdAddrA == WrAddr)) begin
            DataOutA = DataIn;
        end
        if (fwd && (RdAddrB == WrAddr)) begin
            DataOutB = DataIn;
        end
    end
`else
    // Read ports show stored contents; a write appears from the next cycle
    always_comb begin
        DataOutA = mem[RdAddrA];
        DataOutB = mem[RdAddrB];
    end
`endif

endmodule : regfile_param

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default 32x8 instance plus a 16x4 instance.
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
// Inputs are driven 1 time unit after the rising edge and sampled shortly after.
module tb_regfile_param;

    logic        clk;
    logic        CLRn;
    logic [31:0] DataIn;
    logic [2:0]  WrAddr;
    logic        regWE;
    logic        wr_ready;
    logic [2:0]  RdAddrA;
    logic [2:0]  RdAddrB;
    logic [31:0] DataOutA;
    logic [31:0] DataOutB;
    logic        clr_req;
    logic        busy;

    logic [15:0] d2_DataIn;
    logic [1:0]  d2_WrAddr;
    logic        d2_regWE;
    logic        d2_wr_ready;
    logic [1:0]  d2_RdAddrA;
    logic [1:0]  d2_RdAddrB;
    logic [15:0] d2_DataOutA;
    logic [15:0] d2_DataOutB;
    logic        d2_clr_req;
    logic        d2_busy;

    int n_chk;
    int n_err;

    regfile_param dut (
        .clk      (clk),
        .CLRn     (CLRn),
        .DataIn   (DataIn),
        .WrAddr   (WrAddr),
        .regWE    (regWE),
        .wr_ready (wr_ready),
        .RdAddrA  (RdAddrA),
        .RdAddrB  (RdAddrB),
        .DataOutA (DataOutA),
        .DataOutB (DataOutB),
        .clr_req  (clr_req),
        .busy     (busy)
    );

    regfile_param #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut16 (
        .clk      (clk),
        .CLRn     (CLRn),
        .DataIn   (d2_DataIn),
        .WrAddr   (d2_WrAddr),
        .regWE    (d2_regWE),
        .wr_ready (d2_wr_ready),
        .RdAddrA  (d2_RdAddrA),
        .RdAddrB  (d2_RdAddrB),
        .DataOutA (d2_DataOutA),
        .DataOutB (d2_DataOutB),
        .clr_req  (d2_clr_req),
        .busy     (d2_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        WrAddr = a;
        DataIn = d;
        regWE  = 1'b1;
        tick();
        regWE  = 1'b0;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 32'(17 * (i + 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int g;
        n_chk = 0;
        n_err = 0;
        CLRn = 1'b1; DataIn = '0; WrAddr = '0; regWE = 1'b0;
        RdAddrA = '0; RdAddrB = '0; clr_req = 1'b0;
        d2_DataIn = '0; d2_WrAddr = '0; d2_regWE = 1'b0;
        d2_RdAddrA = '0; d2_RdAddrB = '0; d2_clr_req = 1'b0;

        // Reset state
        #2 CLRn = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            RdAddrA = 3'(i); RdAddrB = 3'(7 - i); #1;
            chk("rst_rd_a", DataOutA, 32'h0);
            chk("rst_rd_b", DataOutB, 32'h0);
        end
        tick();
        CLRn = 1'b1;
        #1;
        RdAddrA = 3'd3; RdAddrB = 3'd6; #1;
        chk("post_rst_a", DataOutA, 32'h0);
        chk("post_rst_b", DataOutB, 32'h0);

        // Write then dual read of the same address
        tick();
        wr(3'd3, 32'hDEADBEEF);
        RdAddrA = 3'd3; RdAddrB = 3'd3; #1;
        chk("rd_same_a", DataOutA, 32'hDEADBEEF);
        chk("rd_same_b", DataOutB, 32'hDEADBEEF);

        // Fill, then clear with mid-sequence inspection
        fill();
        RdAddrA = 3'd7; RdAddrB = 3'd0; #1;
        chk("fill_7", DataOutA, 32'h88);
        chk("fill_0", DataOutB, 32'h11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bc = 0;
        if (busy) bc++;
        chk("clr_wr_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) bc++;
        end
        RdAddrA = 3'd0; RdAddrB = 3'd1; #1;
        chk("mid_clr_0", DataOutA, 32'h0);
        chk("mid_clr_1", DataOutB, 32'h0);
        RdAddrA = 3'd2; RdAddrB = 3'd5; #1;
        chk("mid_clr_2", DataOutA, 32'h0);
        chk("mid_clr_5", DataOutB, 32'h66);
        RdAddrA = 3'd3; #1;
        chk("mid_clr_3", DataOutA, 32'h44);
        g = 0;
        while (busy && g < 40) begin
            tick();
            g++;
            if (busy) bc++;
        end
        chk("clr_busy_cycles", 32'(bc), 32'd8);
        for (int i = 0; i < 8; i++) begin
            RdAddrA = 3'(i); #1;
            chk("post_clr_zero", DataOutA, 32'h0);
        end

        // Write coinciding with clr_req, then a held write during the clear
        tick();
        WrAddr = 3'd6; DataIn = 32'h77; regWE = 1'b1; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        WrAddr = 3'd2; DataIn = 32'hA5A5A5A5;
        RdAddrA = 3'd2; RdAddrB = 3'd6; #1;
        chk("sim_wr_commit", DataOutB, 32'h77);
        bc = 0;
        g = 0;
        while (busy && g < 40) begin
            bc++;
            chk("held_wr_ready", 32'(wr_ready), 32'd0);
            chk("held_no_write", DataOutA, 32'h0);
            if (bc == 3) clr_req = 1'b1;
            tick();
            clr_req = 1'b0;
            #1;
            g++;
        end
        chk("ignore_clr_req", 32'(bc), 32'd8);
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        chk("sim_wr_cleared", DataOutB, 32'h0);
`ifdef REGFILE_BYPASS_EN
        chk("held_first_cycle", DataOutA, 32'hA5A5A5A5);
`else
        chk("held_first_cycle", DataOutA, 32'h0);
`endif
        tick();
        regWE = 1'b0;
        #1;
        chk("held_committed", DataOutA, 32'hA5A5A5A5);

        // Same-cycle read of the address being written
        wr(3'd4, 32'h0BADF00D);
        RdAddrA = 3'd4; RdAddrB = 3'd5;
        WrAddr = 3'd4; DataIn = 32'h12345678; regWE = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_a", DataOutA, 32'h12345678);
`else
        chk("bypass_a", DataOutA, 32'h0BADF00D);
`endif
        chk("bypass_b_other", DataOutB, 32'h0);
        tick();
        regWE = 1'b0;
        #1;
        chk("after_wr_a", DataOutA, 32'h12345678);

        // Reset in the middle of a clear
        fill();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        RdAddrA = 3'd7; RdAddrB = 3'd4; #1;
        chk("pre_abort_7", DataOutA, 32'h88);
        chk("pre_abort_4", DataOutB, 32'h55);
        #2 CLRn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_ready", 32'(wr_ready), 32'd1);
        chk("abort_rd_7", DataOutA, 32'h0);
        chk("abort_rd_4", DataOutB, 32'h0);
        #3 CLRn = 1'b1;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            RdAddrA = 3'(i); #1;
            chk("abort_zero", DataOutA, 32'h0);
        end
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bc = 0;
        g = 0;
        while (busy && g < 40) begin
            bc++;
            tick();
            g++;
        end
        chk("abort_reclear_cycles", 32'(bc), 32'd8);

        // 16x4 instance
        d2_WrAddr = 2'd3; d2_DataIn = 16'hBEEF; d2_regWE = 1'b1;
        tick();
        d2_regWE = 1'b0;
        d2_RdAddrA = 2'd3; d2_RdAddrB = 2'd0; #1;
        chk("w16_rd_3", 32'(d2_DataOutA), 32'h0000BEEF);
        chk("w16_rd_0", 32'(d2_DataOutB), 32'h0);
        d2_clr_req = 1'b1;
        tick();
        d2_clr_req = 1'b0;
        chk("w16_ptr_start", 32'(dut16.clr_ptr), 32'd0);
        bc = 0;
        g = 0;
        while (d2_busy && g < 40) begin
            bc++;
            tick();
            g++;
        end
        chk("w16_busy_cycles", 32'(bc), 32'd4);
        chk("w16_ptr_wrap", 32'(dut16.clr_ptr), 32'd0);
        chk("w16_cleared", 32'(d2_DataOutA), 32'h0);
        chk("w16_wr_ready", 32'(d2_wr_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule : tb_regfile_param
